// File: rtl/display_mux_scan_if.sv
// Display scan bus: datapath-side controls and digit data in, board-side segment/anode pins out.
// Pure wiring; no latency and no backpressure.
interface display_mux_scan_if #(
    parameter int N_DIGITS = 4
);
    logic                    enable;
    logic                    load;
    logic [4*N_DIGITS-1:0]   digits;
    logic [N_DIGITS-1:0]     blank_mask;
    logic [6:0]              seg;
    logic [N_DIGITS-1:0]     an;
    logic                    frame_done;

    modport master (
        output enable, load, digits, blank_mask,
        input  seg, an, frame_done
    );

    modport slave (
        input  enable, load, digits, blank_mask,
        output seg, an, frame_done
    );
endinterface

// File: rtl/display_mux_scan.sv
// Time-multiplexed 7-segment scanner with frame-aligned shadow digit updates.
// seg/an are registered, lagging idx by one cycle; no backpressure, load is always accepted.
module display_mux_scan #(
    parameter int N_DIGITS   = 4,
    parameter int DIV        = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              reset,
    display_mux_scan_if.slave bus
);
    localparam int                  IW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int                  PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [PW-1:0]       PRE_LAST = PW'(DIV - 1);
    localparam bit                  AL       = (ACTIVE_LOW != 0);
    localparam logic [6:0]          SEG_OFF  = {7{AL}};
    localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{AL}};

    logic [PW-1:0]           r_pre;
    logic [IW-1:0]           r_idx;
    logic [4*N_DIGITS-1:0]   r_shadow_dig;
    logic [N_DIGITS-1:0]     r_shadow_mask;
    logic [4*N_DIGITS-1:0]   r_pend_dig;
    logic [N_DIGITS-1:0]     r_pend_mask;
    logic                    r_pend_vld;
    logic [6:0]              r_seg;
    logic [N_DIGITS-1:0]     r_an;
    logic                    r_frame_done;

    logic                    w_tick;
    logic                    w_wrap;
    logic [3:0]              w_cur_dig;
    logic                    w_cur_blank;
    logic [N_DIGITS-1:0]     w_an_hot;
    logic [6:0]              w_seg_hot;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        s = 7'h00;
        case (h)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign w_tick = bus.enable && (r_pre == PRE_LAST);
    assign w_wrap = w_tick && (r_idx == IDX_LAST);

    always_comb begin
        w_cur_dig   = 4'h0;
        w_cur_blank = 1'b0;
        w_an_hot    = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_cur_dig   = r_shadow_dig[4*i +: 4];
                w_cur_blank = r_shadow_mask[i];
                w_an_hot[i] = 1'b1;
            end
        end
        w_seg_hot = w_cur_blank ? 7'h00 : hex7(w_cur_dig);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_idx <= w_wrap ? '0 : r_idx + IW'(1);
        end else if (bus.enable) begin
            r_pre <= r_pre + PW'(1);
        end
    end

    // A load coinciding with the wrap goes straight to the shadow so it beats any older pending value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow_dig  <= '0;
            r_shadow_mask <= '0;
            r_pend_dig    <= '0;
            r_pend_mask   <= '0;
            r_pend_vld    <= 1'b0;
        end else if (w_wrap && bus.load) begin
            r_shadow_dig  <= bus.digits;
            r_shadow_mask <= bus.blank_mask;
            r_pend_vld    <= 1'b0;
        end else if (w_wrap && r_pend_vld) begin
            r_shadow_dig  <= r_pend_dig;
            r_shadow_mask <= r_pend_mask;
            r_pend_vld    <= 1'b0;
        end else if (bus.load) begin
            r_pend_dig    <= bus.digits;
            r_pend_mask   <= bus.blank_mask;
            r_pend_vld    <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg        <= SEG_OFF;
            r_an         <= AN_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (bus.enable) begin
                r_seg <= w_seg_hot ^ SEG_OFF;
                r_an  <= w_an_hot ^ AN_OFF;
            end else begin
                r_seg <= SEG_OFF;
                r_an  <= AN_OFF;
            end
        end
    end

    assign bus.seg        = r_seg;
    assign bus.an         = r_an;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_display_mux_scan.sv
// Directed bench: N=4/DIV=4/active-high scanner for framing and update rules,
// plus N=1/DIV=1/active-low scanner for the full decode sweep.
module tb_display_mux_scan;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    display_mux_scan_if #(.N_DIGITS(4)) b0 ();
    display_mux_scan_if #(.N_DIGITS(1)) b1 ();

    display_mux_scan #(.N_DIGITS(4), .DIV(4), .ACTIVE_LOW(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    display_mux_scan #(.N_DIGITS(1), .DIV(1), .ACTIVE_LOW(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    logic [6:0] seg_tbl [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive inputs for one cycle, then sample dut0 on the following falling edge.
    task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] m, input logic en,
                        input logic [3:0] ea, input logic [6:0] es, input logic ef, input string tag);
        b0.load       = ld;
        b0.digits     = d;
        b0.blank_mask = m;
        b0.enable     = en;
        @(negedge clk);
        chk({tag, "_an"},  32'(b0.an),         32'(ea));
        chk({tag, "_seg"}, 32'(b0.seg),        32'(es));
        chk({tag, "_fd"},  32'(b0.frame_done), 32'(ef));
        b0.load = 1'b0;
    endtask

    // One 16-cycle frame from an aligned start; segs = {s3,s2,s1,s0}; up to two loads at cycles la1/la2.
    task automatic check_frame(input string tag, input logic [27:0] segs,
                               input int la1, input logic [15:0] v1, input logic [3:0] m1,
                               input int la2, input logic [15:0] v2, input logic [3:0] m2);
        for (int k = 1; k <= 16; k++) begin
            int slot;
            slot = (k - 1) / 4;
            step((k == la1) || (k == la2), (k == la2) ? v2 : v1, (k == la2) ? m2 : m1, 1'b1,
                 4'(1 << slot), segs[slot*7 +: 7], k == 16, $sformatf("%s_k%0d", tag, k));
        end
    endtask

    initial begin
        logic [27:0] segs;
        n_checks = 0;
        n_errors = 0;
        seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        reset = 1'b1;
        b0.enable = 1'b0; b0.load = 1'b0; b0.digits = '0; b0.blank_mask = '0;
        b1.enable = 1'b0; b1.load = 1'b0; b1.digits = '0; b1.blank_mask = '0;
        repeat (2) @(negedge clk);
        chk("rst_an0",  32'(b0.an),         32'h0);
        chk("rst_seg0", 32'(b0.seg),        32'h00);
        chk("rst_fd0",  32'(b0.frame_done), 32'h0);
        chk("rst_an1",  32'(b1.an),         32'h1);
        chk("rst_seg1", 32'(b1.seg),        32'h7F);
        chk("rst_fd1",  32'(b1.frame_done), 32'h0);
        reset = 1'b0;

        // Load while disabled lands in pending; first frame still shows zeros.
        step(1'b1, 16'h3210, 4'h0, 1'b0, 4'h0, 7'h00, 1'b0, "ld_dis");
        check_frame("f1", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
        check_frame("f2", {7'h4F, 7'h5B, 7'h06, 7'h3F}, 6, 16'h1234, 4'h0, 0, 16'h0, 4'h0);
        // Mid-frame AAAA load must not disturb slots 2,3 of the 1234 frame.
        check_frame("f3", {7'h06, 7'h5B, 7'h4F, 7'h66}, 6, 16'hAAAA, 4'h0, 0, 16'h0, 4'h0);
        // Older pending 5555, then a load on the wrap cycle itself.
        check_frame("f4", {7'h77, 7'h77, 7'h77, 7'h77}, 3, 16'h5555, 4'h0, 16, 16'h9876, 4'h0);
        check_frame("f5", {7'h6F, 7'h7F, 7'h07, 7'h7D}, 2, 16'h3210, 4'b0101, 0, 16'h0, 4'h0);
        segs = {7'h4F, 7'h00, 7'h06, 7'h00};
        check_frame("f6", segs, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

        // Pause for 10 cycles two cycles into slot 2; slot 2 then finishes its remaining two cycles.
        for (int k = 1; k <= 10; k++)
            step(1'b0, 16'h0, 4'h0, 1'b1, 4'(1 << ((k - 1) / 4)), segs[((k - 1) / 4)*7 +: 7], 1'b0,
                 $sformatf("pre_en_k%0d", k));
        for (int j = 0; j < 10; j++)
            step(1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 7'h00, 1'b0, $sformatf("dis_%0d", j));
        for (int k = 11; k <= 16; k++)
            step(1'b0, 16'h0, 4'h0, 1'b1, 4'(1 << ((k - 1) / 4)), segs[((k - 1) / 4)*7 +: 7], k == 16,
                 $sformatf("resume_k%0d", k));

        // Reset mid-frame with 5555 pending: outputs clear at once and the load is lost.
        for (int k = 1; k <= 6; k++)
            step(k == 3, 16'h5555, 4'h0, 1'b1, 4'(1 << ((k - 1) / 4)), segs[((k - 1) / 4)*7 +: 7], 1'b0,
                 $sformatf("prerst_k%0d", k));
        #2 reset = 1'b1;
        #1;
        chk("mrst_an",  32'(b0.an),         32'h0);
        chk("mrst_seg", 32'(b0.seg),        32'h00);
        chk("mrst_fd",  32'(b0.frame_done), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        check_frame("r1", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
        check_frame("r2", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

        // Decode sweep on the single-digit active-low instance: every enabled cycle is a wrap.
        b0.enable = 1'b0;
        b1.enable = 1'b1;
        @(negedge clk);
        for (int v = 0; v < 16; v++) begin
            logic [6:0] exp_seg;
            exp_seg = ~seg_tbl[v];
            b1.load   = 1'b1;
            b1.digits = 4'(v);
            @(negedge clk);
            b1.load = 1'b0;
            @(negedge clk);
            chk($sformatf("sweep_seg_%0h", v), 32'(b1.seg),        32'(exp_seg));
            chk($sformatf("sweep_an_%0h", v),  32'(b1.an),         32'h0);
            chk($sformatf("sweep_fd_%0h", v),  32'(b1.frame_done), 32'h1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
